// File: rtl/axi_sync_fifo.sv
// axi_sync_fifo: single-clock FWFT FIFO for AXI channel payloads.
// Provides an occupancy count, programmable almost-full/almost-empty flags,
// a synchronous flush, and one-cycle overflow/underflow pulses.
module axi_sync_fifo #(
  parameter int DATA_W    = 43,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              almost_full,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // The pointer MSB is a wrap bit, so DEPTH must be a power of two.
  initial begin : param_check
    assert ((DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0))
      else $fatal(1, "DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              wr_en;
  logic              rd_en;
  logic              clr;

  // Flags are decoded from the registered count, so they never glitch.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AFULL_TH));
  assign almost_empty = (count <= CW'(AEMPTY_TH));

  // A rejected push or pop leaves the FIFO untouched; clearing overrides both.
  assign clr   = rst | flush;
  assign wr_en = push & ~full & ~clr;
  assign rd_en = pop & ~empty & ~clr;

  // The head is visible without a pop, and reads as zero while empty.
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  // Storage is datapath state, so it is neither reset nor flushed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  // Pointers, occupancy and error pulses are cleared by rst or flush.
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + PW'(1);
      end
      if (rd_en) begin
        rptr <= rptr + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= push & full;
      underflow <= pop & empty;
    end
  end

endmodule

// File: tb/tb_axi_sync_fifo.sv
// tb_axi_sync_fifo: directed and randomized checks of axi_sync_fifo against
// a queue-based reference model of the FIFO behaviour.
module tb_axi_sync_fifo;

  localparam int DATA_W    = 43;
  localparam int DEPTH     = 4;
  localparam int AFULL_TH  = DEPTH - 1;
  localparam int AEMPTY_TH = 1;
  localparam int CW        = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic              full;
  logic              almost_full;
  logic [DATA_W-1:0] rdata;
  logic              empty;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: contents held as a plain queue, error pulses as bits.
  logic [DATA_W-1:0] model_q [$];
  logic              exp_ovf = 1'b0;
  logic              exp_udf = 1'b0;

  axi_sync_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push         (push),
    .wdata        (wdata),
    .full         (full),
    .almost_full  (almost_full),
    .pop          (pop),
    .rdata        (rdata),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare all outputs.
  task automatic cyc(input logic r, input logic f, input logic p, input logic q,
                     input logic [DATA_W-1:0] d);
    int n;
    rst   = r;
    flush = f;
    push  = p;
    pop   = q;
    wdata = d;
    @(posedge clk);
    n = model_q.size();
    if (r || f) begin
      model_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      exp_ovf = p && (n == DEPTH);
      exp_udf = q && (n == 0);
      if (q && n > 0) void'(model_q.pop_front());
      if (p && n < DEPTH) model_q.push_back(d);
    end
    #1;
    n = model_q.size();
    chk("count",        64'(count),        64'(n));
    chk("empty",        64'(empty),        64'(n == 0));
    chk("full",         64'(full),         64'(n == DEPTH));
    chk("almost_full",  64'(almost_full),  64'(n >= AFULL_TH));
    chk("almost_empty", 64'(almost_empty), 64'(n <= AEMPTY_TH));
    chk("rdata",        64'(rdata),        (n > 0) ? 64'(model_q[0]) : 64'(0));
    chk("overflow",     64'(overflow),     64'(exp_ovf));
    chk("underflow",    64'(underflow),    64'(exp_udf));
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic r_p, r_q, r_f;

    // Reset held two cycles with push asserted.
    cyc(1, 0, 1, 0, 43'h55);
    cyc(1, 0, 1, 0, 43'h66);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    cyc(0, 0, 0, 0, '0);

    // Fill 1..4, then drain in order.
    for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 0, DATA_W'(i));
    chk("fill_full", 64'(full), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_head", 64'(rdata), 64'(i));
      cyc(0, 0, 0, 1, '0);
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Overflow: push with pop while full drops the push.
    for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 0, DATA_W'(i));
    cyc(0, 0, 1, 1, 43'h5);
    chk("ovf_count", 64'(count), 64'd3);
    chk("ovf_pulse", 64'(overflow), 64'd1);
    cyc(0, 0, 0, 0, '0);
    chk("ovf_pulse_end", 64'(overflow), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      chk("ovf_drain", 64'(rdata), 64'(i));
      cyc(0, 0, 0, 1, '0);
    end

    // Back-to-back overflow gives one pulse per offending cycle.
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, DATA_W'(i + 16));
    cyc(0, 0, 1, 0, 43'h99);
    cyc(0, 0, 1, 0, 43'h9a);
    chk("ovf_b2b", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, '0);

    // Underflow with a simultaneous push.
    cyc(0, 0, 1, 1, 43'hA);
    chk("udf_pulse", 64'(underflow), 64'd1);
    chk("udf_rdata", 64'(rdata), 64'hA);
    chk("udf_count", 64'(count), 64'd1);

    // Wrap-around: steady push/pop at count 2.
    cyc(0, 0, 1, 0, 43'hB);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1, DATA_W'(32'h100 + i));
    chk("wrap_count", 64'(count), 64'd2);

    // Flush at count 3 with push asserted.
    cyc(0, 0, 1, 0, 43'hC);
    cyc(0, 1, 1, 0, 43'hD);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_rdata", 64'(rdata), 64'd0);
    cyc(0, 0, 1, 0, 43'h7);
    chk("flush_push", 64'(rdata), 64'h7);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      d   = DATA_W'({$urandom(), $urandom()});
      r_p = ($urandom_range(0, 3) != 0);
      r_q = ($urandom_range(0, 3) != 0);
      if (i < 200) r_q = ($urandom_range(0, 2) == 0);
      r_f = ($urandom_range(0, 40) == 0);
      cyc(($urandom_range(0, 90) == 0), r_f, r_p, r_q, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
